// File: rtl/config_table_seq.sv
// -----------------------------------------------------------------------------
// config_table_seq
//   Two-bank configuration table (control words + wide immediates) with a
//   built-in sequencer. The host loads a program through the write port, then
//   a single `start` walks [start_add .. end_add] (wrapping through DEPTH-1)
//   and streams every executable entry to the compute pipeline.
//
//   Optional feature macro: CFG_TABLE_LOOP_EN
//     When defined, the `loop_cnt` port exists and the programmed range is
//     replayed loop_cnt additional times (loop_cnt + 1 passes in total).
//
// Ports
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   wr_valid/wr_ready    : write handshake; wr_ready is high only while IDLE
//   wr_bank              : 0 = control bank (low CTRL_W bits), 1 = immediate bank
//   wr_add, wr_data      : write address / payload
//   start                : one-cycle run request (ignored while busy)
//   start_add, end_add   : inclusive run range
//   abort                : return to IDLE on the next edge, no done pulse
//   busy, done, halted   : status (halted is sticky until the next start)
//   out_valid/out_ready  : emit handshake
//   out_ctrl/out_imm/out_add : emitted entry and its address
//   loop_cnt             : extra passes (only with CFG_TABLE_LOOP_EN)
//   dbg_state            : current sequencer state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and payload stable until that edge.
// -----------------------------------------------------------------------------
module config_table_seq #(
  parameter int PHIT_W = 512,
  parameter int CTRL_W = 21,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_add,
  input  logic [PHIT_W-1:0] wr_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_add,
  input  logic [ADDR_W-1:0] end_add,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [PHIT_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_add,
`ifdef CFG_TABLE_LOOP_EN
  input  logic [7:0]        loop_cnt,
`endif
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [CTRL_W-1:0] r_ctrl_mem [DEPTH];
  logic [PHIT_W-1:0] r_imm_mem  [DEPTH];
  logic [DEPTH-1:0]  r_loaded;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_end_add;
  logic              r_halted;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [PHIT_W-1:0] r_out_imm;
  logic [ADDR_W-1:0] r_out_add;
`ifdef CFG_TABLE_LOOP_EN
  logic [ADDR_W-1:0] r_start_add;
  logic [7:0]        r_loop_rem;
`endif

  logic w_wr_fire;
  logic w_exec;

  assign w_wr_fire = wr_valid && wr_ready;
  // Executable = control word written since reset and its valid bit set.
  assign w_exec    = r_loaded[r_pc] && r_ctrl_mem[r_pc][CTRL_W-1];

  assign wr_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_valid = (r_state == S_EMIT);
  assign halted    = r_halted;
  assign out_ctrl  = r_out_ctrl;
  assign out_imm   = r_out_imm;
  assign out_add   = r_out_add;
  assign dbg_state = r_state;

  // Bank storage is deliberately not reset; only the loaded flags are.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      if (wr_bank) r_imm_mem[wr_add]  <= wr_data;
      else         r_ctrl_mem[wr_add] <= wr_data[CTRL_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loaded    <= '0;
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_end_add   <= '0;
      r_halted    <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_imm   <= '0;
      r_out_add   <= '0;
`ifdef CFG_TABLE_LOOP_EN
      r_start_add <= '0;
      r_loop_rem  <= '0;
`endif
    end else begin
      if (w_wr_fire && !wr_bank) r_loaded[wr_add] <= 1'b1;

      // Abort beats every other transition, including an EMIT handshake.
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_pc        <= start_add;
              r_end_add   <= end_add;
              r_halted    <= 1'b0;
`ifdef CFG_TABLE_LOOP_EN
              r_start_add <= start_add;
              r_loop_rem  <= loop_cnt;
`endif
              r_state     <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (w_exec) begin
              r_out_ctrl <= r_ctrl_mem[r_pc];
              r_out_imm  <= r_imm_mem[r_pc];
              r_out_add  <= r_pc;
              r_state    <= S_EMIT;
            end else begin
              r_halted   <= 1'b1;
              r_state    <= S_DONE;
            end
          end
          S_EMIT: begin
            if (out_ready) begin
              if (r_pc == r_end_add) begin
`ifdef CFG_TABLE_LOOP_EN
                if (r_loop_rem != 8'd0) begin
                  r_loop_rem <= r_loop_rem - 8'd1;
                  r_pc       <= r_start_add;
                  r_state    <= S_FETCH;
                end else begin
                  r_state    <= S_DONE;
                end
`else
                r_state <= S_DONE;
`endif
              end else begin
                // Power-of-two DEPTH makes the natural overflow the wrap.
                r_pc    <= r_pc + ADDR_W'(1);
                r_state <= S_FETCH;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_config_table_seq.sv
// -----------------------------------------------------------------------------
// tb_config_table_seq
//   Directed + randomized bench for config_table_seq. A behavioural model of
//   the table (arrays of control words, immediates, loaded flags) predicts the
//   list of emitted addresses for each run and whether the run halts.
// -----------------------------------------------------------------------------
module tb_config_table_seq;

  localparam int PHIT_W = 512;
  localparam int CTRL_W = 21;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic              wr_bank = 1'b0;
  logic [ADDR_W-1:0] wr_add = '0;
  logic [PHIT_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_add = '0;
  logic [ADDR_W-1:0] end_add = '0;
  logic              abort = 1'b0;
  logic              busy, done, halted, out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [PHIT_W-1:0] out_imm;
  logic [ADDR_W-1:0] out_add;
  logic [1:0]        dbg_state;
`ifdef CFG_TABLE_LOOP_EN
  logic [7:0]        loop_cnt = 8'd0;
`endif

  config_table_seq dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank),
    .wr_add(wr_add), .wr_data(wr_data),
    .start(start), .start_add(start_add), .end_add(end_add), .abort(abort),
    .busy(busy), .done(done), .halted(halted),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_imm(out_imm), .out_add(out_add),
`ifdef CFG_TABLE_LOOP_EN
    .loop_cnt(loop_cnt),
`endif
    .dbg_state(dbg_state)
  );

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model + scoreboard ----------------
  int checks = 0;
  int errors = 0;

  logic [CTRL_W-1:0] m_ctrl   [DEPTH];
  logic [PHIT_W-1:0] m_imm    [DEPTH];
  bit                m_loaded [DEPTH];
  logic [ADDR_W-1:0] exp_q[$];
  bit                exp_halt;

  task automatic chk(input string tag, input logic [PHIT_W-1:0] obs,
                     input logic [PHIT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected emit list: walk the inclusive range with wrap, once per pass,
  // stopping the whole run at the first non-executable entry.
  task automatic build_expect(input int sa, input int ea, input int loops);
    int a;
    exp_q.delete();
    exp_halt = 0;
    for (int p = 0; p <= loops; p++) begin
      a = sa;
      forever begin
        if (!(m_loaded[a] && m_ctrl[a][CTRL_W-1])) begin
          exp_halt = 1;
          return;
        end
        exp_q.push_back(ADDR_W'(a));
        if (a == ea) break;
        a = (a + 1) % DEPTH;
      end
    end
  endtask

  function automatic logic [PHIT_W-1:0] rand_wide();
    logic [PHIT_W-1:0] v;
    for (int i = 0; i < PHIT_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wr(input bit bank, input int a, input logic [PHIT_W-1:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_bank = bank; wr_add = ADDR_W'(a); wr_data = d;
    chk("wr_ready_idle", {511'b0, wr_ready}, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    if (bank) m_imm[a] = d;
    else begin
      m_ctrl[a]   = d[CTRL_W-1:0];
      m_loaded[a] = 1;
    end
  endtask

  task automatic kick(input int sa, input int ea, input int loops);
    build_expect(sa, ea, loops);
    @(negedge clk);
    start = 1'b1; start_add = ADDR_W'(sa); end_add = ADDR_W'(ea);
`ifdef CFG_TABLE_LOOP_EN
    loop_cnt = 8'(loops);
`endif
  endtask

  // mode 0: ready always high; 1: one high / two low; 2: random.
  // want_done > 0 also checks the cycle (relative to start) of the done pulse.
  task automatic watch_run(input int mode, input int want_done);
    bit seen_done = 0;
    logic [ADDR_W-1:0] a;
    for (int cyc = 1; cyc <= 300 && !seen_done; cyc++) begin
      @(negedge clk);
      start = 1'b0; wr_valid = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (cyc == 1) chk("busy_after_start", {511'b0, busy}, 1);
      if (out_valid) begin
        chk("emit_expected", {511'b0, out_valid}, {511'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
          a = exp_q[0];
          chk("out_add", {508'b0, out_add}, {508'b0, a});
          chk("out_ctrl", {491'b0, out_ctrl}, {491'b0, m_ctrl[a]});
          chk("out_imm", out_imm, m_imm[a]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (done) begin
        seen_done = 1;
        chk("halted_at_done", {511'b0, halted}, {511'b0, exp_halt});
        chk("emits_remaining", exp_q.size(), 0);
        if (want_done > 0) chk("done_cycle", cyc, want_done);
      end
    end
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done pulse within 300 cycles");
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("busy_after_done", {511'b0, busy}, 0);
    chk("done_one_cycle", {511'b0, done}, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] b;
    logic [PHIT_W-1:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      m_loaded[i] = 0; m_ctrl[i] = '0; m_imm[i] = '0;
    end

    // Reset values (sampled while reset is asserted).
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {511'b0, out_valid}, 0);
    chk("rst_busy", {511'b0, busy}, 0);
    chk("rst_done", {511'b0, done}, 0);
    chk("rst_halted", {511'b0, halted}, 0);
    chk("rst_wr_ready", {511'b0, wr_ready}, 1);
    chk("rst_out_ctrl", {491'b0, out_ctrl}, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_add", {508'b0, out_add}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic program: ctrl = valid | op=i, imm = {64{i}}.
    for (int i = 0; i < 4; i++) begin
      b = 8'(i);
      d = '0; d[CTRL_W-1] = 1'b1; d[CTRL_W-2 -: 3] = 3'(i);
      wr(0, i, d);
      wr(1, i, {64{b}});
    end
    kick(0, 3, 0); watch_run(0, 9);
    kick(0, 3, 0); watch_run(1, 0);

    // Load every entry with random valid data; wrapping range 14..1.
    for (int i = 0; i < DEPTH; i++) begin
      d = rand_wide(); d[CTRL_W-1] = 1'b1;
      wr(0, i, d);
      wr(1, i, rand_wide());
    end
    kick(14, 1, 0); watch_run(2, 0);
    chk("wrap_len", 4, 4 - exp_q.size());

    // Non-executable entry stops the run; halted is sticky, cleared by start.
    d = {PHIT_W{1'b1}}; d[CTRL_W-1] = 1'b0;
    wr(0, 2, d);
    kick(0, 3, 0); watch_run(0, 0);
    @(negedge clk);
    chk("halted_sticky", {511'b0, halted}, 1);
    kick(4, 5, 0); watch_run(0, 0);

    // Abort during the second EMIT; a write while busy is refused.
    kick(8, 11, 0);
    @(negedge clk); start = 1'b0;                        // cycle 1: FETCH
    wr_valid = 1'b1; wr_bank = 1'b0; wr_add = 4'd5; wr_data = '0;
    chk("wr_ready_busy", {511'b0, wr_ready}, 0);
    @(negedge clk); wr_valid = 1'b0; out_ready = 1'b1;   // cycle 2: first EMIT
    chk("abort_emit0_add", {508'b0, out_add}, 8);
    @(negedge clk); out_ready = 1'b0;                    // cycle 3: FETCH
    @(negedge clk);                                      // cycle 4: second EMIT
    chk("abort_emit1_valid", {511'b0, out_valid}, 1);
    chk("abort_emit1_add", {508'b0, out_add}, 9);
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk); abort = 1'b0; out_ready = 1'b0;
    chk("abort_valid_drop", {511'b0, out_valid}, 0);
    chk("abort_busy", {511'b0, busy}, 0);
    chk("abort_wr_ready", {511'b0, wr_ready}, 1);
    chk("abort_no_done", {511'b0, done}, 0);
    @(negedge clk);
    chk("abort_no_done_late", {511'b0, done}, 0);
    kick(5, 5, 0); watch_run(0, 3);                      // entry 5 untouched

    // Write and start in the same cycle: FETCH sees the new word.
    d = rand_wide(); d[CTRL_W-1] = 1'b1;
    m_ctrl[7] = d[CTRL_W-1:0]; m_loaded[7] = 1;
    build_expect(7, 7, 0);
    @(negedge clk);
    wr_valid = 1'b1; wr_bank = 1'b0; wr_add = 4'd7; wr_data = d;
    start = 1'b1; start_add = 4'd7; end_add = 4'd7;
`ifdef CFG_TABLE_LOOP_EN
    loop_cnt = 8'd0;
`endif
    watch_run(0, 3);

    // Randomized programs and ranges with random back-pressure.
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 3; k++) begin
        d = rand_wide(); d[CTRL_W-1] = ($urandom_range(0, 7) != 0);
        wr(0, $urandom_range(0, DEPTH - 1), d);
        wr(1, $urandom_range(0, DEPTH - 1), rand_wide());
      end
      kick($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 0);
      watch_run(2, 0);
    end

`ifdef CFG_TABLE_LOOP_EN
    d = rand_wide(); d[CTRL_W-1] = 1'b1; wr(0, 0, d);
    d = rand_wide(); d[CTRL_W-1] = 1'b1; wr(0, 1, d);
    kick(0, 1, 2);
    chk("loop_len", exp_q.size(), 6);
    watch_run(0, 13);
`endif

    // Reset mid-run clears outputs and loaded flags.
    for (int i = 0; i < DEPTH; i++) begin
      d = rand_wide(); d[CTRL_W-1] = 1'b1; wr(0, i, d);
    end
    kick(0, 15, 0);
    repeat (4) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {511'b0, out_valid}, 0);
    chk("midrst_busy", {511'b0, busy}, 0);
    chk("midrst_done", {511'b0, done}, 0);
    chk("midrst_wr_ready", {511'b0, wr_ready}, 1);
    chk("midrst_out_imm", out_imm, 0);
    chk("midrst_out_add", {508'b0, out_add}, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) m_loaded[i] = 0;
    kick(0, 0, 0); watch_run(0, 2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_table_seq.md
# config_table_seq

Parametrised successor to the static configuration table. It holds a control bank (CTRL_W-bit entries) and an immediate bank (PHIT_W-bit entries), both loaded through a valid/ready write port sized to match the QDMA AXIS beat. A built-in sequencer walks a programmed address range and streams each executable entry to the compute pipeline over a valid/ready handshake. Replacing the combinational read lets the host load a program once and fire it with a single `start`.

## Interface
- `PHIT_W`, 512: immediate width and write-data width.
- `CTRL_W`, 21: control-word width. Layout, MSB first: valid(1), op(3), operand1(2), operand2(2), R/W(1), address(12).
- `DEPTH`, 16: entries per bank. Must be a power of two, ≥2.
- `ADDR_W`, $clog2(DEPTH): address width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accepted when high with `wr_valid`.
- `wr_bank` in 1: 0 selects the control bank (stores `wr_data[CTRL_W-1:0]`). 1 selects the immediate bank (stores all of `wr_data`).
- `wr_add` in ADDR_W: write address.
- `wr_data` in PHIT_W: write payload.
- `start` in 1: one-cycle run request.
- `start_add`, `end_add` in ADDR_W: inclusive run range.
- `abort` in 1: stop the sequencer.
- `busy` out 1: sequencer not IDLE.
- `done` out 1: one-cycle pulse at the end of a run.
- `halted` out 1: sticky. Set when a run stops early on a non-executable entry. Cleared by the next accepted `start`.
- `out_valid` out 1, `out_ready` in 1: emit handshake.
- `out_ctrl` out CTRL_W, `out_imm` out PHIT_W, `out_add` out ADDR_W: emitted entry and its address.
- `loop_cnt` in 8: present only with `CFG_TABLE_LOOP_EN` (see Configuration).

## Operation
- Per-entry `loaded` flags cover the control bank only. All flags clear on reset. A flag sets when its control entry is written.
- Bank RAM contents are not reset.
- An entry is executable when `loaded[a]` is set and `ctrl[a][CTRL_W-1]` is 1.
- `wr_ready` = (state == IDLE). A write completes on a `wr_valid && wr_ready` edge.
- FSM states: IDLE, FETCH, EMIT, DONE.
- IDLE:
  - `start` captures `start_add` into `pc` and the range registers, clears `halted`, and moves to FETCH.
  - A write and a `start` in the same cycle are both accepted. FETCH then sees the new data.
- FETCH:
  - Synchronous read of both banks at `pc`.
  - Executable entry: register the data into the `out_*` registers, go to EMIT.
  - Non-executable entry: set `halted`, go to DONE. Nothing is emitted.
- EMIT:
  - `out_valid` is 1. `out_*` hold stable until `out_ready`.
  - On handshake with `pc == end_add`: go to DONE.
  - On handshake otherwise: `pc <= pc + 1` modulo DEPTH, go to FETCH.
- DONE: `done` = 1 for one cycle, then IDLE.
- `start_add > end_add` wraps through DEPTH-1 to 0. `start_add == end_add` is a run of exactly one entry.
- `abort` in any non-IDLE state goes to IDLE on the next edge and drops `out_valid` with no handshake. No `done` pulse. `halted` is unchanged. `abort` wins over a simultaneous handshake.
- `start` while busy is ignored.

## Timing
- Reset values: `out_valid`, `out_ctrl`, `out_imm`, `out_add`, `busy`, `done`, `halted` are all 0. State is IDLE, so `wr_ready` reads 1 during and after reset.
- Cycle 0: `start` sampled. Cycle 1: FETCH, `busy` = 1. Cycle 2: `out_valid` = 1.
- With `out_ready` held high, one entry is emitted every 2 cycles.
- `done` is high in the cycle after the last handshake (or after the failing FETCH). `busy` is low the cycle after that.
- Reset assertion mid-run forces IDLE and all outputs to their reset values immediately, and clears all `loaded` flags.

## Configuration
- `CFG_TABLE_LOOP_EN` defined:
  - The `loop_cnt` port exists and is captured at start.
  - After the `end_add` handshake, if the remaining loop count is nonzero: decrement it, `pc <= start_add`, go to FETCH.
  - Total passes = `loop_cnt` + 1.
- Not defined: the port is absent and the run is a single pass.

## Test plan
- After reset: write ctrl[0..3] = valid|op=i and imm[0..3] = {64{i}}. `start_add`=0, `end_add`=3, `out_ready`=1. Expect 4 emits with `out_add` 0,1,2,3 and matching data, then `done` at cycle 9 after start, `halted`=0.
- Same program with `out_ready` toggling 1 cycle high / 2 cycles low. Expect data stable while stalled, and no loss or duplication.
- `start_add`=14, `end_add`=1 with all entries loaded and valid. Expect emits at 14, 15, 0, 1.
- ctrl[2] written with the valid bit 0, range 0..3. Expect emits at 0 and 1, then `done` with `halted`=1.
- Assert `abort` during the second EMIT. Expect `out_valid` to drop next cycle, no `done`, and `wr_ready` back to 1. A write attempted while busy is not accepted.
- With `CFG_TABLE_LOOP_EN`, `loop_cnt`=2 over range 0..1. Expect the sequence 0,1,0,1,0,1, then `done`.
